// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: limits, mode
// encodings and the pointer wrap helper.
package mux_pkg;

    localparam int MAX_N_IN = 16;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Wrap increment; 5 bits covers indices and counts up to MAX_N_IN.
    function automatic logic [4:0] rr_next(input logic [4:0] ptr, input logic [4:0] n);
        logic [4:0] nxt;
        nxt = (ptr >= (n - 5'd1)) ? 5'd0 : (ptr + 5'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr,
// wrapping at N_IN-1.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    int sum_s;
    int idx_s;

    // Scan farthest-to-nearest so the candidate closest to ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum_s   = 0;
        idx_s   = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            sum_s   = int'(ptr) + k;
            idx_s   = (sum_s >= N_IN) ? (sum_s - N_IN) : sum_s;
            gnt_vld = req[idx_s] ? 1'b1 : gnt_vld;
            gnt_idx = req[idx_s] ? SEL_W'(idx_s) : gnt_idx;
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with a registered output stage,
// selectable between manual channel select and round-robin arbitration.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_chan
);

    logic [SEL_W-1:0]  ptr_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic [SEL_W-1:0]  out_chan_r;

    logic              rr_vld_s;
    logic [SEL_W-1:0]  rr_idx_s;
    logic              gnt_vld_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic              load_s;
    logic              xfer_s;
    logic              gnt_in_valid_s;
    logic [DATA_W-1:0] gnt_data_s;
    logic [N_IN-1:0]   in_ready_s;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_r),
        .gnt_vld (rr_vld_s),
        .gnt_idx (rr_idx_s)
    );

    // Grant selection, load/transfer decode and per-channel ready.
    always_comb begin
        gnt_vld_s      = 1'b0;
        gnt_idx_s      = '0;
        gnt_in_valid_s = 1'b0;
        gnt_data_s     = '0;
        in_ready_s     = '0;
        if (mode == MODE_RR) begin
            gnt_vld_s = rr_vld_s;
            gnt_idx_s = rr_idx_s;
        end else begin
            gnt_vld_s = (int'(sel) < N_IN);
            gnt_idx_s = sel;
        end
        // Reset forces load low so no producer sees ready during reset.
        load_s = rst_n & (~out_valid_r | out_ready);
        // Explicit compare loop keeps out-of-range indices from reaching a bit select.
        for (int i = 0; i < N_IN; i++) begin
            gnt_in_valid_s = (gnt_idx_s == SEL_W'(i)) ? in_valid[i] : gnt_in_valid_s;
            gnt_data_s     = (gnt_idx_s == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : gnt_data_s;
            in_ready_s[i]  = load_s & gnt_vld_s & (gnt_idx_s == SEL_W'(i));
        end
        xfer_s = load_s & gnt_vld_s & gnt_in_valid_s;
    end

    // Output register: capture on transfer, drain on idle load, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_chan_r  <= '0;
        end else if (load_s) begin
            if (xfer_s) begin
                out_data_r  <= gnt_data_s;
                out_valid_r <= 1'b1;
                out_chan_r  <= gnt_idx_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer advances past the channel just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (xfer_s && (mode == MODE_RR)) begin
            ptr_r <= SEL_W'(rr_next(5'(gnt_idx_s), 5'(N_IN)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed self-checking bench for mux_rr_stream: a 4-channel instance for
// the main scenarios and a 3-channel instance for out-of-range select.
module tb_mux_rr_stream;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [1:0]  out_chan4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_chan3;

    int err_cnt;
    int chk_cnt;

    mux_rr_stream #(.N_IN(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_chan(out_chan4)
    );

    mux_rr_stream #(.N_IN(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] man_exp [4];
    logic [1:0] sp_chan [4];
    logic [3:0] sp_rdy  [4];

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        man_exp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        sp_chan = '{2'd3, 2'd1, 2'd3, 2'd1};
        sp_rdy  = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

        rst_n      = 1'b0;
        in_data4   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid4  = 4'hF;
        mode4      = 1'b0;
        sel4       = 2'd0;
        out_ready4 = 1'b1;
        in_data3   = {8'h32, 8'h21, 8'h10};
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        sel3       = 2'd3;
        out_ready3 = 1'b1;

        // Reset held three cycles with every channel valid
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready4), 32'h0);
            tick();
        end
        chk("rst_out_valid", 32'(out_valid4), 32'h0);
        chk("rst_out_data", 32'(out_data4), 32'h0);
        chk("rst_out_chan", 32'(out_chan4), 32'h0);

        // Manual mode, sel stepped 0..3
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            tick();
            chk("man_data", 32'(out_data4), 32'(man_exp[s]));
            chk("man_chan", 32'(out_chan4), 32'(s));
            chk("man_valid", 32'(out_valid4), 32'h1);
        end

        // Round-robin, all valid: ptr still 0 after manual mode
        mode4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_all_chan", 32'(out_chan4), 32'(k % 4));
        end

        // Sparse: prime ptr to 2 via a single channel-1 beat
        in_valid4 = 4'b0010;
        tick();
        chk("rr_prime_chan", 32'(out_chan4), 32'h1);
        in_valid4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_sparse_rdy", 32'(in_ready4), 32'(sp_rdy[k]));
            tick();
            chk("rr_sparse_chan", 32'(out_chan4), 32'(sp_chan[k]));
        end

        // Backpressure holding B1
        mode4     = 1'b0;
        sel4      = 2'd1;
        in_valid4 = 4'hF;
        tick();
        chk("bp_load", 32'(out_data4), 32'hB1);
        out_ready4 = 1'b0;
        sel4       = 2'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready4), 32'h0);
            tick();
            chk("bp_hold_data", 32'(out_data4), 32'hB1);
            chk("bp_hold_valid", 32'(out_valid4), 32'h1);
            chk("bp_hold_chan", 32'(out_chan4), 32'h1);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 32'(in_ready4), 32'b0100);
        tick();
        chk("bp_next_data", 32'(out_data4), 32'hC2);
        chk("bp_next_chan", 32'(out_chan4), 32'h2);

        // Out-of-range select on the 3-channel instance
        @(negedge clk);
        chk("oor_in_ready", 32'(in_ready3), 32'h0);
        chk("oor_out_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        tick();
        chk("n3_data", 32'(out_data3), 32'h32);
        chk("n3_chan", 32'(out_chan3), 32'h2);

        // One-cycle reset mid-stream; ptr was 2 beforehand
        chk("mid_pre_valid", 32'(out_valid4), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(in_ready4), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(out_valid4), 32'h0);
        chk("mid_rst_data", 32'(out_data4), 32'h0);
        rst_n = 1'b1;
        mode4 = 1'b1;
        tick();
        chk("mid_ptr0_chan", 32'(out_chan4), 32'h0);
        chk("mid_ptr0_data", 32'(out_data4), 32'hA0);
        tick();
        chk("mid_ptr1_chan", 32'(out_chan4), 32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
# mux_rr_stream

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output. It has a registered output stage and two selection modes: a manual select that generalises the existing 4:1 select encoding, and fair round-robin arbitration. It sits between multiple producer streams and a single consumer, and forwards one beat per cycle at full throughput.

## Interface
- `N_IN`, default 4: number of input channels; legal range 2 to 16.
- `DATA_W`, default 8: data width of each channel, at least 1.
- `SEL_W`, default $clog2(N_IN): width of `sel` and `out_chan`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  N_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `in_valid`  in  N_IN  per-channel valid.
- `in_ready`  out  N_IN  per-channel ready; one-hot or zero.
- `mode`  in  1  0 = manual (`sel`), 1 = round-robin.
- `sel`  in  SEL_W  channel chosen in manual mode; values at or above N_IN select nothing.
- `out_data`  out  DATA_W  registered data.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  consumer ready.
- `out_chan`  out  SEL_W  index of the channel that sourced `out_data`.

## Operation
- Output register is free when `out_valid`=0 or `out_ready`=1; call this `load`.
- **Grant, manual mode:** grant = `sel` if `sel` < N_IN, else none. `in_valid` does not affect which channel is granted.
- **Grant, round-robin mode:** grant = first i with `in_valid[i]`=1, scanning from `ptr` upward and wrapping at N_IN-1 to 0. No valid input means no grant.
- `in_ready[g]` = `load` for the granted channel g. Every other `in_ready` bit is 0.
- **Transfer:** occurs on channel g when `in_valid[g]` and `in_ready[g]` are both 1. The register then captures `in_data[g]` and g, and `out_valid` goes to 1.
- When `load`=1 and no transfer occurs, `out_valid` goes to 0.
- When `load`=0, all output registers hold their values.
- **Pointer `ptr`:** SEL_W bits, reset 0. It updates only on a transfer in round-robin mode, to g+1, wrapping N_IN-1 to 0. Manual mode leaves `ptr` unchanged.
- **Mode or `sel` change:** takes effect on the very next cycle's grant. A beat already in the output register is unaffected.
- **Reset:** applied mid-transfer, it discards the held beat; nothing is replayed.
- Data is never duplicated, dropped or reordered within a channel.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0.
  - All `in_ready` bits are 0 during reset, because `load` is forced to 0 while `rst_n`=0.
- Latency: a beat transferred at edge k is visible on `out_*` after edge k and is consumed at the first later edge where `out_ready`=1.
- Throughput: one beat per cycle while `out_ready` is held at 1.
- `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `in_valid` and `ptr`. There is no combinational path from `in_data`.
- Backpressure:
  - When `out_ready`=0 and `out_valid`=1, all `in_ready` bits are 0.
  - `out_data`, `out_chan` and `out_valid` remain stable until the beat is accepted.
- Fairness: with all N_IN channels continuously valid in round-robin mode, each channel is granted exactly once in every N_IN consecutive transfers.

## Structure
- Shared package `mux_pkg`:
  - `MAX_N_IN`=16.
  - Mode encodings `MODE_MANUAL`=1'b0 and `MODE_RR`=1'b1.
  - Function `rr_next(ptr, n)`, implementing the wrap increment.
- Sub-module `rr_arbiter` (params `N_IN`; inputs `req`, `ptr`; outputs `gnt_vld`, `gnt_idx`):
  - Purely combinational rotate-priority search.
  - `ptr` storage stays in the top level.
- The top level holds:
  - The mode mux between `sel` and the `rr_arbiter` grant.
  - The `load` logic.
  - The output register.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with all `in_valid`=1 -> `out_valid`=0, `in_ready`=0, `out_data`=0, `ptr`=0.
2. **Manual mode:** N_IN=4, DATA_W=8, data {i3,i2,i1,i0}={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, `out_ready`=1; step `sel` 0,1,2,3 -> `out_data` is A0,B1,C2,D3 one cycle after each step, and `out_chan` matches `sel`.
3. **Round-robin, all valid:** continuous valid on all channels, `out_ready`=1, 8 cycles -> `out_chan` sequence 0,1,2,3,0,1,2,3.
4. **Round-robin, sparse:** only channels 1 and 3 valid, starting with `ptr`=2 -> `out_chan` sequence 3,1,3,1, and `in_ready[0]` and `in_ready[2]` never assert.
5. **Backpressure:** drop `out_ready` for 4 cycles while `out_valid`=1 holding 8'hB1 -> `out_data` stays 8'hB1, `in_ready`=0 throughout, and the next beat appears after exactly one accept.
6. **Out-of-range select and reset mid-stream:**
   - `sel`=3 with N_IN=3 -> no transfer.
   - Assert `rst_n`=0 for one cycle while `out_valid`=1 -> the next cycle shows `out_valid`=0 and `ptr`=0.
